hdec2_decim_out: RTL
====================

# hdec2_decim_out

Output stage placed directly downstream of the 21-tap half-band decimating FIR (hdec_2). The FIR computes a 20-bit result every clock. This block:
- discards the FIR start-up transient,
- keeps every second sample (decimation by 2),
- rounds and saturates the 20-bit result to the system sample width,
- buffers the result in a small FIFO with a valid/ready handshake for the next polyphase stage.

## Interface
- WIN, 20, input width; matches the FIR output.
- SHIFT, 8, number of LSBs dropped by rounding (SHIFT ≥ 1).
- WOUT, 12, output width, signed two's complement.
- DISCARD, 20, number of accepted input samples dropped after reset or sync (0 allowed).
- DEPTH, 4, FIFO depth in entries (power of 2, ≥ 2).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  din carries a new FIR output this cycle.
- din  in  WIN  signed FIR output.
- sync  in  1  one-cycle pulse; realigns the decimation phase and restarts warm-up.
- clr_flags  in  1  one-cycle pulse; clears both sticky flags.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts dout.
- dout  out  WOUT  signed FIFO head, driven from registered storage.
- sat_flag  out  1  sticky; set when a kept sample saturated.
- ovr_flag  out  1  sticky; set when a rounded sample was dropped because the FIFO was full.

## Operation
- **Phase bit.** Toggles on every in_valid. A sample is kept only when phase == 0.
- **sync.** Forces phase to 0 for the current cycle's sample, so that sample is phase 0, and reloads the warm-up counter.
- **Warm-up counter.**
  - Loaded with DISCARD on reset or sync.
  - Decrements on each in_valid while nonzero.
  - While the counter is nonzero, samples still toggle the phase but are never kept.
  - With DISCARD = 20 and in_valid tied high, input index 20 is the first kept sample.
- **Rounding.** Round half up:
  - Compute r = (din + 2^(SHIFT−1)) >>> SHIFT.
  - Sign-extend din by 1 bit before the add, so the sum cannot wrap.
- **Saturation.**
  - If r > 2^(WOUT−1)−1, output 2^(WOUT−1)−1 and set sat_flag.
  - If r < −2^(WOUT−1), output −2^(WOUT−1) and set sat_flag.
  - Otherwise output r[WOUT−1:0].
- **Stage-1 register.** Holds the rounded value plus a valid bit. sync clears the stage-1 valid bit, so a sample in flight is dropped. sync does not flush the FIFO.
- **FIFO push.** Each stage-1 valid entry is pushed into the FIFO.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the sample is discarded and ovr_flag is set.
- **FIFO pop.** A pop occurs when dout_valid && dout_ready.
- **Empty FIFO.**
  - Pop is not possible; dout holds its last value; dout_valid = 0.
  - Push and pop in the same cycle is not possible when empty (no bypass).
- **Pointers.** Read and write pointers wrap modulo DEPTH. A separate count register of width log2(DEPTH)+1 distinguishes full from empty.
- **Flags.**
  - Set conditions take priority over clr_flags in the same cycle.
  - Flags are only cleared by clr_flags or reset.
- **Reset.** dout = 0, dout_valid = 0, sat_flag = 0, ovr_flag = 0, FIFO empty, phase = 0, warm-up counter = DISCARD, stage-1 invalid.
  - Reset overrides sync, clr_flags and all handshakes.
  - Reset asserted mid-stream empties the FIFO at the next edge.

## Timing
- **Latency.** A kept sample presented at edge k enters stage 1 at edge k. It is written to the FIFO at edge k+1. With an empty FIFO, dout_valid is high in the cycle after edge k+1: two edges from input to output.
- **Throughput.** One output per two in_valid; sustained with dout_ready high.
- **Flag timing.** sat_flag rises with the stage-1 capture (edge k). ovr_flag rises at the rejected push edge (k+1).
- **Handshake.** dout and dout_valid change only on clk edges. While dout_valid && !dout_ready, dout holds its value.
- **sync and in_valid together.** If sync and in_valid are both high, the current sample counts as the first warm-up sample. With DISCARD = 0 that sample is kept.

## Test plan
- **Warm-up and decimation.** Reset with defaults, in_valid = 1, dout_ready = 1, din = n<<8 for index n. Required: first output 20, then 22, 24, 26 …, one output every 2 cycles, no flags set.
- **Rounding.**
  - din = 0x00180 (1.5) → dout = 2.
  - din = 0xFFE80 (−1.5) → dout = −1.
  - din = 0x0007F → dout = 0.
  - din = 0x00080 → dout = 1.
  - Use DISCARD = 0 and feed each value on the kept phase.
- **Saturation.**
  - din = 0x7FFFF → dout = 2047, sat_flag = 1.
  - din = 0x80000 → dout = −2048; sat_flag is not newly set (verify after a clr_flags).
  - clr_flags and a saturating sample in the same cycle → sat_flag stays 1.
- **Backpressure.** dout_ready = 0, push 5 kept samples with values 1..5.
  - Required: ovr_flag = 1; then dout_ready = 1 yields 1, 2, 3, 4 in order, dout_valid drops after 4.
  - Full FIFO with simultaneous pop and push: no overrun.
- **Sync mid-stream.** With DISCARD = 0, assert sync with in_valid on an odd-phase sample. Required: that sample is kept. The stage-1 sample in flight is dropped. Samples already in the FIFO are delivered unchanged.
- **Reset mid-operation.** Assert reset with 3 FIFO entries and both flags set. Required: after one edge, dout_valid = 0, dout = 0, flags = 0. Warm-up restarts, so the first output after release is input index DISCARD.

Source files
------------

// File: rtl/hdec2_decim_out.sv
// hdec2_decim_out
// Output stage behind the 21-tap half-band decimating FIR (hdec_2).
// It drops the FIR start-up transient and keeps every second sample.
// Kept samples are rounded half up and saturated to WOUT bits.
// The result is buffered in a small FIFO with a valid/ready handshake.
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high; clears all state
//   in_valid    din carries a new FIR output this cycle
//   din         signed FIR output, WIN bits
//   sync        one-cycle pulse; realigns decimation phase, restarts warm-up
//   clr_flags   one-cycle pulse; clears both sticky flags
//   dout_valid  FIFO not empty
//   dout_ready  consumer accepts dout
//   dout        signed FIFO head, WOUT bits, registered
//   sat_flag    sticky; a kept sample saturated
//   ovr_flag    sticky; a rounded sample was dropped on a full FIFO
module hdec2_decim_out #(
    parameter int WIN     = 20,
    parameter int SHIFT   = 8,
    parameter int WOUT    = 12,
    parameter int DISCARD = 20,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic signed [WIN-1:0]  din,
    input  logic                   sync,
    input  logic                   clr_flags,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic signed [WOUT-1:0] dout,
    output logic                   sat_flag,
    output logic                   ovr_flag
);
    localparam int RW   = WIN + 1 - SHIFT;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int WU_W = (DISCARD < 2) ? 1 : $clog2(DISCARD + 1);

    localparam logic signed [WIN:0]    HALF   = (WIN+1)'(2 ** (SHIFT - 1));
    localparam logic signed [RW-1:0]   MAXV   = RW'(2 ** (WOUT - 1) - 1);
    localparam logic signed [RW-1:0]   MINV   = RW'(-(2 ** (WOUT - 1)));
    localparam logic signed [WOUT-1:0] MAXV_O = {1'b0, {(WOUT-1){1'b1}}};
    localparam logic signed [WOUT-1:0] MINV_O = {1'b1, {(WOUT-1){1'b0}}};

    // One guard bit on top of din keeps the rounding add from wrapping.
    function automatic logic signed [RW-1:0] round_hu(input logic signed [WIN-1:0] x);
        logic signed [WIN:0] sum;
        sum = {x[WIN-1], x};
        sum = sum + HALF;
        return RW'(sum >>> SHIFT);
    endfunction

    function automatic logic is_sat(input logic signed [RW-1:0] r);
        return (r > MAXV) || (r < MINV);
    endfunction

    function automatic logic signed [WOUT-1:0] sat_val(input logic signed [RW-1:0] r);
        if (r > MAXV)
            return MAXV_O;
        else if (r < MINV)
            return MINV_O;
        else
            return r[WOUT-1:0];
    endfunction

    // ---- stage 0: phase / warm-up qualification and rounding of din ----
    logic                   phase_q;
    logic [WU_W-1:0]        wu_q;
    logic                   phase_eff;
    logic [WU_W-1:0]        wu_eff;
    logic                   keep_p0;
    logic signed [RW-1:0]   r_p0;
    logic                   sat_p0;
    logic signed [WOUT-1:0] q_p0;

    // sync acts on the current sample: it is phase 0 and the first warm-up sample.
    assign phase_eff = sync ? 1'b0 : phase_q;
    assign wu_eff    = sync ? WU_W'(DISCARD) : wu_q;
    assign keep_p0   = in_valid && !phase_eff && (wu_eff == '0);
    assign r_p0      = round_hu(din);
    assign sat_p0    = is_sat(r_p0);
    assign q_p0      = sat_val(r_p0);

    logic                   vld_p1;
    logic signed [WOUT-1:0] data_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
            wu_q    <= WU_W'(DISCARD);
            vld_p1  <= 1'b0;
        end else begin
            if (in_valid) begin
                phase_q <= ~phase_eff;
                wu_q    <= (wu_eff != '0) ? wu_eff - WU_W'(1) : wu_eff;
            end else begin
                phase_q <= phase_eff;
                wu_q    <= wu_eff;
            end
            vld_p1 <= keep_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (keep_p0)
            data_p1 <= q_p0;
    end

    // ---- stage 1: FIFO write; sync drops the sample sitting in stage 1 ----
    logic signed [WOUT-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          cnt;
    logic                   push;
    logic                   pop;
    logic                   push_ok;

    assign dout_valid = (cnt != '0);
    assign push       = vld_p1 && !sync;
    assign pop        = dout_valid && dout_ready;
    assign push_ok    = push && ((cnt != CW'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= data_p1;
    end

    // dout is a register that always mirrors the head the FIFO will have
    // after this edge, so it holds its last value once the FIFO drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            dout     <= '0;
            sat_flag <= 1'b0;
            ovr_flag <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push_ok)
                cnt <= cnt - CW'(1);

            if (pop) begin
                if (cnt != CW'(1))
                    dout <= mem[rd_ptr + AW'(1)];
                else if (push_ok)
                    dout <= data_p1;
            end else if (!dout_valid && push_ok) begin
                dout <= data_p1;
            end

            if (keep_p0 && sat_p0)
                sat_flag <= 1'b1;
            else if (clr_flags)
                sat_flag <= 1'b0;

            if (push && !push_ok)
                ovr_flag <= 1'b1;
            else if (clr_flags)
                ovr_flag <= 1'b0;
        end
    end

endmodule
